icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
// - Direct-mapped, one-word-per-block instruction cache between the datapath's imem port and the memory controller.
// - Hits return combinationally, in the same cycle as the request. Misses stall the datapath (ihit=0) while a two-state FSM fetches the word.
// - Provides hit/miss counters for performance runs and a synchronous flush.
// PARAMETERS
// - NSETS      16   number of frames; power of 2, >=2; IDXW = $clog2(NSETS)
// - TAGW       30-IDXW   tag width: addr[31:2+IDXW]
// PORTS
// - CLK        in   1   clock, all state on posedge
// - nRST       in   1   asynchronous active-low reset
// - imemREN    in   1   datapath instruction read request
// - imemaddr   in   32  instruction byte address; bits [1:0] ignored
// - ihit       out  1   imemload valid this cycle
// - imemload   out  32  instruction word
// - iREN       out  1   memory read request
// - iaddr      out  32  memory word address, {addr[31:2],2'b00}
// - iwait      in   1   memory busy; iload valid in a cycle where iREN=1 and iwait=0
// - iload      in   32  memory read data
// - flush      in   1   invalidate all frames (synchronous)
// - hit_count  out  32  number of hit cycles, wraps
// - miss_count out  32  number of misses started, wraps
// BEHAVIOUR
// - Frame: {valid, tag[TAGW], data[32]}. idx = addr[2+IDXW-1:2]; tag = addr[31:2+IDXW].
// - Reset (async): all valid=0, state=IDLE, latched addr=0, counters=0.
//   Outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
// - Hit (combinational): hit = imemREN & state==IDLE & valid[idx] & tag[idx]==tag.
//   ihit=hit; imemload = hit ? data[idx] : 0.
// - FSM IDLE
//   - imemREN & !hit & !flush: latch {imemaddr[31:2],2'b00}, increment miss_count, go to FETCH.
//   - Otherwise stay in IDLE.
//   - hit_count increments on every cycle where hit=1.
// - FSM FETCH
//   - Drive iREN=1 and iaddr=latched address. ihit=0, imemload=0.
//   - iwait=1: hold in FETCH.
//   - iwait=0: write the frame at the latched index with valid=1, latched tag and data=iload; go to IDLE.
//   - The refilled word hits combinationally in the next cycle, so miss latency = memory latency + 1 cycle.
// - iREN=0 and iaddr=0 whenever state is IDLE.
// - Request dropped or address changed during FETCH: the fetch still completes with the latched address and fills the frame.
//   The new address is looked up in IDLE after the fill.
// - flush in IDLE: all valid bits are cleared at the clock edge. ihit is forced to 0 that cycle and no miss starts that cycle.
// - flush in FETCH: all valid bits are cleared at the edge. If the fill completes on the same edge, the filled frame is written valid; the fill has priority for that one frame.
// - Conflict: two addresses with the same idx evict each other. There is no replacement state.
// - Counters wrap 0xFFFFFFFF -> 0.
// - nRST asserted mid-FETCH: iREN drops to 0 immediately, no frame is written, FSM returns to IDLE.
// TESTING
// - Cold miss: reset, then imemREN=1, imemaddr=0x0, iwait=1 for 3 cycles, then iwait=0 with iload=0x8C010004.
//   -> iREN=1 and iaddr=0x0 for 4 cycles, then ihit=1 and imemload=0x8C010004 in the next cycle; miss_count=1.
// - Hit stream: after 0x0 and 0x4 are filled, request 0x0, 0x4, 0x0 on consecutive cycles.
//   -> ihit=1 every cycle, iREN=0, hit_count increases by 3.
// - Conflict (NSETS=16): fill 0x00, then request 0x40 (same idx 0, different tag).
//   -> miss and refill; a following request to 0x00 misses again; miss_count=3.
// - Address change mid-miss: miss on 0x8, change imemaddr to 0xC before iwait falls.
//   -> iaddr stays 0x8, frame 2 is filled, then a separate miss on 0xC.
// - Flush: fill 0x10, pulse flush one cycle, request 0x10.
//   -> ihit=0 during the flush cycle and a new miss afterwards. Separately, flush on the same cycle as fill completion -> the filled frame is valid.
// - Reset mid-FETCH: assert nRST low while iwait=1.
//   -> iREN=0 asynchronously, no frame is valid after release, counters are 0.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache between the datapath imem port
// and the memory controller. Hits are combinational; misses refill through a two-state FSM.
module icache #(
    parameter int unsigned NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        flush,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int unsigned IDXW = $clog2(NSETS);
    localparam int unsigned TAGW = 30 - IDXW;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t           state, next_state;
    logic [NSETS-1:0] valid;
    logic [TAGW-1:0]  tags  [NSETS];
    logic [31:0]      words [NSETS];
    logic [31:0]      lat_addr;

    logic [IDXW-1:0]  idx, lat_idx;
    logic [TAGW-1:0]  tag, lat_tag;
    logic             hit, start_miss, fill;

    assign idx     = imemaddr[2+IDXW-1:2];
    assign tag     = imemaddr[31:2+IDXW];
    assign lat_idx = lat_addr[2+IDXW-1:2];
    assign lat_tag = lat_addr[31:2+IDXW];

    // A flush cycle never hits and never starts a miss.
    always_comb begin
        hit        = imemREN && (state == IDLE) && !flush && valid[idx] && (tags[idx] == tag);
        start_miss = imemREN && (state == IDLE) && !flush && !hit;
        fill       = (state == FETCH) && !iwait;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_miss) next_state = FETCH;
            FETCH:   if (!iwait)     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ihit     = hit;
        imemload = hit ? words[idx] : '0;
        iREN     = (state == FETCH);
        iaddr    = (state == FETCH) ? lat_addr : '0;
    end

    // Fill is applied after the flush clear so the frame being refilled survives.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid      <= '0;
            lat_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (flush) valid <= '0;
            if (fill)  valid[lat_idx] <= 1'b1;
            if (start_miss) begin
                lat_addr   <= {imemaddr[31:2], 2'b00};
                miss_count <= miss_count + 32'd1;
            end
            if (hit) hit_count <= hit_count + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[lat_idx]  <= lat_tag;
            words[lat_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache: cold miss, hit stream, conflict, mid-miss address change,
// flush (alone and coincident with a fill) and reset during a fetch.
module tb_icache;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    icache #(.NSETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Miss on a, one wait cycle, then refill with d; returns just after the fill edge.
    task automatic fill(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = a; iwait = 1'b1;
        #1 check("fill_miss_ihit", {31'd0, ihit}, 32'd0);
        @(negedge CLK);
        iwait = 1'b0; iload = d;
        #1 check("fill_iaddr", iaddr, {a[31:2], 2'b00});
        @(posedge CLK);
    endtask

    initial begin
        nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0; flush = 1'b0;
        #12;
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iREN", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_misses", miss_count, 32'd0);
        @(negedge CLK); nRST = 1'b1;

        // Cold miss: 3 wait cycles then data; 4 cycles of iREN.
        @(negedge CLK);
        imemREN = 1'b1; imemaddr = 32'h0; iwait = 1'b1;
        #1 check("cold_ihit", {31'd0, ihit}, 32'd0);
        check("cold_idle_iREN", {31'd0, iREN}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            iwait = (i < 3); iload = 32'h8C010004;
            #1 check("cold_iREN", {31'd0, iREN}, 32'd1);
            check("cold_iaddr", iaddr, 32'h0);
        end
        @(negedge CLK);
        #1 check("cold_hit", {31'd0, ihit}, 32'd1);
        check("cold_data", imemload, 32'h8C010004);
        check("cold_misses", miss_count, 32'd1);
        check("cold_hits_before", hit_count, 32'd0);

        // Hit stream over 0x0 / 0x4 / 0x0.
        fill(32'h4, 32'h11111111);
        @(negedge CLK); imemaddr = 32'h0;
        #1 check("hs0_hit", {31'd0, ihit}, 32'd1);
        check("hs0_data", imemload, 32'h8C010004);
        check("hs0_iREN", {31'd0, iREN}, 32'd0);
        @(negedge CLK); imemaddr = 32'h4;
        #1 check("hs1_hit", {31'd0, ihit}, 32'd1);
        check("hs1_data", imemload, 32'h11111111);
        @(negedge CLK); imemaddr = 32'h0;
        #1 check("hs2_hit", {31'd0, ihit}, 32'd1);
        @(negedge CLK); imemREN = 1'b0;
        #1 check("hs_hits", hit_count, 32'd4);
        check("hs_misses", miss_count, 32'd2);

        // Conflict: 0x40 evicts 0x00, then 0x00 misses again.
        fill(32'h40, 32'hAAAA0040);
        @(negedge CLK); imemaddr = 32'h40;
        #1 check("cf_hit40", {31'd0, ihit}, 32'd1);
        check("cf_data40", imemload, 32'hAAAA0040);
        @(negedge CLK); imemaddr = 32'h0; iwait = 1'b1;
        #1 check("cf_miss0", {31'd0, ihit}, 32'd0);
        @(negedge CLK); iwait = 1'b0; iload = 32'h8C010004;
        #1 check("cf_iaddr", iaddr, 32'h0);
        @(negedge CLK); imemREN = 1'b0;
        #1 check("cf_misses", miss_count, 32'd4);
        check("cf_hits", hit_count, 32'd5);

        // Address change mid-miss.
        @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h8; iwait = 1'b1;
        @(negedge CLK); imemaddr = 32'hC;
        #1 check("ac_iaddr_hold", iaddr, 32'h8);
        @(negedge CLK); iwait = 1'b0; iload = 32'h22220008;
        #1 check("ac_iaddr_fill", iaddr, 32'h8);
        @(negedge CLK); iwait = 1'b1;
        #1 check("ac_missC", {31'd0, ihit}, 32'd0);
        check("ac_idle_iaddr", iaddr, 32'h0);
        @(negedge CLK); iwait = 1'b0; iload = 32'h3333000C;
        #1 check("ac_iaddrC", iaddr, 32'hC);
        @(negedge CLK); imemaddr = 32'h8;
        #1 check("ac_hit8", imemload, 32'h22220008);
        @(negedge CLK); imemaddr = 32'hC;
        #1 check("ac_hitC", imemload, 32'h3333000C);
        check("ac_misses", miss_count, 32'd6);

        // Flush alone.
        fill(32'h10, 32'h44440010);
        @(negedge CLK); imemaddr = 32'h10; flush = 1'b1;
        #1 check("fl_ihit", {31'd0, ihit}, 32'd0);
        check("fl_imemload", imemload, 32'd0);
        @(negedge CLK); flush = 1'b0; iwait = 1'b1;
        #1 check("fl_miss", {31'd0, ihit}, 32'd0);
        check("fl_no_miss_started", miss_count, 32'd7);
        @(negedge CLK); iwait = 1'b0; iload = 32'h55550010;
        @(negedge CLK);
        #1 check("fl_refill", imemload, 32'h55550010);

        // Flush coincident with fill completion.
        @(negedge CLK); imemaddr = 32'h14; iwait = 1'b1;
        @(negedge CLK); iwait = 1'b0; iload = 32'h66660014; flush = 1'b1;
        @(negedge CLK); flush = 1'b0;
        #1 check("ff_hit", {31'd0, ihit}, 32'd1);
        check("ff_data", imemload, 32'h66660014);
        @(negedge CLK); imemaddr = 32'h10;
        #1 check("ff_other_flushed", {31'd0, ihit}, 32'd0);
        imemREN = 1'b0;
        #1 check("ff_hits", hit_count, 32'd9);
        check("ff_misses", miss_count, 32'd9);

        // Reset during a fetch.
        @(negedge CLK); imemREN = 1'b1; imemaddr = 32'h18; iwait = 1'b1;
        @(negedge CLK);
        #1 check("rf_iREN_before", {31'd0, iREN}, 32'd1);
        #1 nRST = 1'b0;
        #1 check("rf_iREN_async", {31'd0, iREN}, 32'd0);
        check("rf_iaddr", iaddr, 32'h0);
        check("rf_hits", hit_count, 32'd0);
        check("rf_misses", miss_count, 32'd0);
        @(negedge CLK); nRST = 1'b1;
        #1 check("rf_no_fill", {31'd0, ihit}, 32'd0);
        imemaddr = 32'h0;
        #1 check("rf_cleared", {31'd0, ihit}, 32'd0);
        imemREN = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
